// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: turns host commands into single bus strobes and returns read data.
// Define AUTO_POLL_EN to add background polling of the interrupt-status registers.
module reg_bus_initiator #(
  parameter int N           = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int POLL_PERIOD = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_wr_i,
  input  logic [ADDR_SIZE-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [7:0]           rsp_rdata_o,
  output logic                 acc_en_o,
  output logic                 wr_en_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [7:0]           wdata_o,
  input  logic [7:0]           rdata_i,
  output logic [N-1:0]         irq_flags_o,
  input  logic [N-1:0]         irq_clr_i,
  output logic                 irq_o,
  output logic [1:0]           state_o
);

  localparam int NUM_STATUS_REGS = ((N + 7) / 8 < 1) ? 1 : (N + 7) / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    POLL   = 2'd3
  } state_t;

  state_t state;
  logic   pending_n;

  assign state_o = state;

`ifdef AUTO_POLL_EN
  localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int IDX_W = (NUM_STATUS_REGS > 1) ? $clog2(NUM_STATUS_REGS) : 1;

  logic [TMR_W-1:0] timer;
  logic             poll_pending;
  logic             poll_wrap;
  logic             poll_last;
  logic [IDX_W-1:0] poll_idx;
  logic [N-1:0]     poll_set;
  logic [N-1:0]     flags_n;

  assign poll_wrap = (timer == TMR_W'(POLL_PERIOD - 1));
  assign poll_last = (poll_idx == IDX_W'(NUM_STATUS_REGS - 1));

  // A wrap in the same cycle the sweep finishes re-arms the next sweep.
  assign pending_n = poll_wrap | (poll_pending & ~((state == POLL) & poll_last));

  always_comb begin
    poll_set = '0;
    if (state == POLL) begin
      for (int i = 0; i < N; i++) begin
        if ((i / 8) == int'(poll_idx)) poll_set[i] = rdata_i[3'(i % 8)];
      end
    end
  end

  // Set beats clear so a flag raised during a clear is never lost.
  assign flags_n = (irq_flags_o & ~irq_clr_i) | poll_set;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      timer        <= '0;
      poll_pending <= 1'b0;
      irq_flags_o  <= '0;
      irq_o        <= 1'b0;
    end else begin
      timer        <= poll_wrap ? '0 : timer + 1'b1;
      poll_pending <= pending_n;
      irq_flags_o  <= flags_n;
      irq_o        <= |flags_n;
    end
  end
`else
  logic unused_cfg;

  assign pending_n   = 1'b0;
  assign irq_flags_o = '0;
  assign irq_o       = 1'b0;
  assign unused_cfg  = (^irq_clr_i) ^ (POLL_PERIOD == 0);
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // cmd_ready_o is registered and never depends on cmd_valid_i; rsp_valid_o, once high,
  // holds with stable rsp_rdata_o until rsp_ready_i is seen high.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      acc_en_o    <= 1'b0;
      wr_en_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
`ifdef AUTO_POLL_EN
      poll_idx    <= '0;
`endif
    end else begin
      acc_en_o <= 1'b0;
      wr_en_o  <= 1'b0;
      case (state)
        IDLE: begin
`ifdef AUTO_POLL_EN
          if (poll_pending) begin
            state       <= POLL;
            acc_en_o    <= 1'b1;
            addr_o      <= ADDR_SIZE'(N);
            poll_idx    <= '0;
            cmd_ready_o <= 1'b0;
          end else
`endif
          if (cmd_valid_i && cmd_ready_o) begin
            state       <= ACCESS;
            acc_en_o    <= 1'b1;
            wr_en_o     <= cmd_wr_i;
            addr_o      <= cmd_addr_i;
            wdata_o     <= cmd_wdata_i;
            cmd_ready_o <= 1'b0;
          end else begin
            cmd_ready_o <= !pending_n;
          end
        end
        ACCESS: begin
          // wr_en_o is still the latched command direction during the strobe.
          if (wr_en_o) begin
            state       <= IDLE;
            cmd_ready_o <= !pending_n;
          end else begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rdata_i;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= !pending_n;
          end
        end
`ifdef AUTO_POLL_EN
        POLL: begin
          if (poll_last) begin
            state       <= IDLE;
            cmd_ready_o <= !pending_n;
          end else begin
            acc_en_o <= 1'b1;
            addr_o   <= addr_o + 1'b1;
            poll_idx <= poll_idx + 1'b1;
          end
        end
`endif
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a small register-file responder model.
module tb_reg_bus_initiator;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       acc_en, wr_en;
  logic [7:0] addr, wdata, rdata;
  logic [7:0] irq_flags, irq_clr;
  logic       irq;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_bus_initiator #(.N(8), .ADDR_SIZE(8), .POLL_PERIOD(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .acc_en_o(acc_en), .wr_en_o(wr_en), .addr_o(addr), .wdata_o(wdata), .rdata_i(rdata),
    .irq_flags_o(irq_flags), .irq_clr_i(irq_clr), .irq_o(irq), .state_o(state)
  );

  // ---------------- responder model + strobe monitor ----------------
  logic [7:0]  mem [0:7] = '{default: 8'h00};
  logic [7:0]  status_q = 8'h00;
  logic [7:0]  status_val = 8'h00;
  logic        status_load = 1'b0;
  logic        prev_acc = 1'b0;
  int          n_host = 0;
  int          n_poll = 0;
  int          n_adjacent = 0;
  logic [16:0] host_q[$];
  logic [16:0] ord_q[$];
  logic [16:0] exp_q[$];

  always_comb begin
    rdata = 8'h00;
    if (acc_en && !wr_en) begin
      if (addr < 8'd8) rdata = mem[addr[2:0]];
      else if (addr == 8'd8) rdata = status_q;
    end
  end

  always @(posedge clk) begin
    prev_acc <= acc_en;
    if (acc_en && prev_acc) n_adjacent <= n_adjacent + 1;
    if (acc_en && wr_en && addr < 8'd8) mem[addr[2:0]] <= wdata;
    if (status_load) status_q <= status_val;
    else if (acc_en && !wr_en && addr == 8'd8) status_q <= 8'h00;
    if (acc_en) begin
      ord_q.push_back({wr_en, addr, wdata});
      if (addr == 8'd8) n_poll <= n_poll + 1;
      else begin
        n_host <= n_host + 1;
        host_q.push_back({wr_en, addr, wdata});
      end
    end
  end

  // ---------------- checker / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. in the strobe cycle.
  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 60 && !done; n++) begin
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_poll_strobe(output logic found);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (acc_en && addr == 8'd8) found = 1'b1;
      else tick();
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    logic found;
    logic [16:0] e;

    vecs[0] = '{wr: 1'b1, addr: 8'd3,   wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{wr: 1'b0, addr: 8'd3,   wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[2] = '{wr: 1'b1, addr: 8'd0,   wdata: 8'h3C, exp_rdata: 8'h00};
    vecs[3] = '{wr: 1'b1, addr: 8'd7,   wdata: 8'hFF, exp_rdata: 8'h00};
    vecs[4] = '{wr: 1'b0, addr: 8'd0,   wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[5] = '{wr: 1'b0, addr: 8'd7,   wdata: 8'h00, exp_rdata: 8'hFF};
    vecs[6] = '{wr: 1'b0, addr: 8'd200, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[7] = '{wr: 1'b1, addr: 8'd1,   wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[8] = '{wr: 1'b0, addr: 8'd1,   wdata: 8'h00, exp_rdata: 8'h5A};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; irq_clr = 8'h00;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_acc_en",    32'(acc_en),    32'd0);
    chk("rst_wr_en",     32'(wr_en),     32'd0);
    chk("rst_addr",      32'(addr),      32'd0);
    chk("rst_wdata",     32'(wdata),     32'd0);
    chk("rst_irq_flags", 32'(irq_flags), 32'd0);
    chk("rst_irq",       32'(irq),       32'd0);
    chk("rst_state",     32'(state),     32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Table: one strobe at T+1, response at T+2 for reads only.
    for (int i = 0; i < 9; i++) begin
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_acc_en", i), 32'(acc_en), 32'd1);
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
      chk($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
      if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_busy", i), 32'(cmd_ready), 32'd0);
      tick();
      chk($sformatf("v%0d_acc_drop", i), 32'(acc_en), 32'd0);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(!vecs[i].wr));
      if (!vecs[i].wr) begin
        chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 32'd0);
      end
    end
    chk("table_strobes", 32'(n_host), 32'd9);
    chk("table_flags", 32'(irq_flags), 32'd0);

    // Response back-pressure: data held, no new command accepted.
    send_cmd(1'b0, 8'd3, 8'h00);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", k), 32'(rsp_rdata), 32'hA5);
      chk($sformatf("bp%0d_ready", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d_acc", k), 32'(acc_en), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release", 32'(rsp_valid), 32'd0);

    // Back-to-back commands with cmd_valid held high.
    host_q.delete();
    exp_q.delete();
    snap = n_adjacent;
    begin
      int idx;
      int cyc;
      logic hs;
      idx = 0;
      cyc = 0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd4; cmd_wdata = 8'h11;
      while (idx < 3 && cyc < 100) begin
        hs = cmd_ready;
        tick();
        cyc++;
        if (hs) begin
          idx++;
          cmd_addr  = 8'(4 + idx);
          cmd_wdata = 8'(8'h11 * (idx + 1));
        end
      end
      cmd_valid = 1'b0;
      chk("b2b_accepted", 32'(idx), 32'd3);
    end
    exp_q.push_back({1'b1, 8'd4, 8'h11});
    exp_q.push_back({1'b1, 8'd5, 8'h22});
    exp_q.push_back({1'b1, 8'd6, 8'h33});
    repeat (3) tick();
    chk("b2b_count", 32'(host_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      if (host_q.size() > 0) chk($sformatf("b2b_strobe%0d", k), 32'(host_q.pop_front()), 32'(e));
    end
    chk("b2b_gaps", 32'(n_adjacent - snap), 32'd0);
    send_cmd(1'b0, 8'd5, 8'h00);
    tick();
    chk("b2b_readback", 32'(rsp_rdata), 32'h22);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while a response is waiting.
    send_cmd(1'b0, 8'd1, 8'h00);
    tick();
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
    rstn = 1'b0;
    tick();
    chk("rr_valid", 32'(rsp_valid), 32'd0);
    chk("rr_rdata", 32'(rsp_rdata), 32'd0);
    chk("rr_addr",  32'(addr),      32'd0);
    chk("rr_acc",   32'(acc_en),    32'd0);
    chk("rr_ready", 32'(cmd_ready), 32'd0);
    chk("rr_state", 32'(state),     32'd0);
    rstn = 1'b1;
    snap = n_host + n_poll;
    repeat (5) tick();
    chk("rr_no_strobes", 32'(n_host + n_poll - snap), 32'd0);
    chk("rr_ready_back", 32'(cmd_ready), 32'd1);

`ifdef AUTO_POLL_EN
    // Poll picks up status bits into sticky flags.
    status_val = 8'h05; status_load = 1'b1;
    tick();
    status_load = 1'b0;
    wait_poll_strobe(found);
    chk("poll_found", 32'(found), 32'd1);
    chk("poll_wr_en", 32'(wr_en), 32'd0);
    tick();
    chk("poll_flags", 32'(irq_flags), 32'h05);
    chk("poll_irq",   32'(irq),       32'd1);
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    chk("clr_flags", 32'(irq_flags), 32'h04);
    chk("clr_irq",   32'(irq),       32'd1);

    // Poll due with a command waiting: poll strobe goes first.
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (state == 2'd0 && !cmd_ready) found = 1'b1;
      else tick();
    end
    chk("prio_pending_seen", 32'(found), 32'd1);
    ord_q.delete();
    send_cmd(1'b1, 8'd2, 8'h77);
    tick();
    chk("prio_count", 32'(ord_q.size()), 32'd2);
    if (ord_q.size() == 2) begin
      chk("prio_first",  32'(ord_q[0][16:8]), 32'({1'b0, 8'd8}));
      chk("prio_second", 32'(ord_q[1]),       32'({1'b1, 8'd2, 8'h77}));
    end

    // Set and clear of the same bit in the poll cycle: set wins.
    status_val = 8'h01; status_load = 1'b1;
    tick();
    status_load = 1'b0;
    irq_clr = 8'h01;
    wait_poll_strobe(found);
    chk("sc_found", 32'(found), 32'd1);
    tick();
    chk("sc_set_wins", 32'(irq_flags), 32'h05);
    tick();
    irq_clr = 8'h00;
    chk("sc_then_clear", 32'(irq_flags), 32'h04);

    // Reset during a poll strobe.
    status_val = 8'h03; status_load = 1'b1;
    tick();
    status_load = 1'b0;
    wait_poll_strobe(found);
    chk("rp_found", 32'(found), 32'd1);
    rstn = 1'b0;
    tick();
    chk("rp_acc",   32'(acc_en),    32'd0);
    chk("rp_state", 32'(state),     32'd0);
    chk("rp_flags", 32'(irq_flags), 32'd0);
    chk("rp_irq",   32'(irq),       32'd0);
    chk("rp_addr",  32'(addr),      32'd0);
    rstn = 1'b1;
    snap = n_host + n_poll;
    repeat (5) tick();
    chk("rp_no_strobes", 32'(n_host + n_poll - snap), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
